// File: rtl/mem_arbiter.sv
// Shared main-memory arbiter between I-cache and D-cache miss/write ports.
// Define ARB_ROUND_ROBIN_EN to alternate grants on contention; default is fixed D priority.
module mem_arbiter #(
    parameter int ADDR_W          = 16,
    parameter int DATA_W          = 16,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] i_mem_addr,
    input  logic              i_mem_ren,
    input  logic              i_mem_wen,
    input  logic [DATA_W-1:0] i_mem_wdata,
    output logic [DATA_W-1:0] i_mem_rdata,
    output logic              i_mem_data_valid,
    output logic              i_stall,
    input  logic [ADDR_W-1:0] d_mem_addr,
    input  logic              d_mem_ren,
    input  logic              d_mem_wen,
    input  logic [DATA_W-1:0] d_mem_wdata,
    output logic [DATA_W-1:0] d_mem_rdata,
    output logic              d_mem_data_valid,
    output logic              d_stall,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_ren,
    output logic              mem_wen,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_data_valid
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {IDLE, I_OWN, D_OWN} state_t;

    state_t            state, state_next, arb_pick;
    logic [CNT_W-1:0]  outst_cnt, cnt_next;
    logic              last_grant, last_grant_next;
    logic              i_req, d_req;
    logic              own_ren, own_wen, own_req;
    logic [ADDR_W-1:0] own_addr;
    logic [DATA_W-1:0] own_wdata;
    logic              cnt_full, cnt_zero, fwd_ren, take_valid, own_stall;

    assign i_req = i_mem_ren | i_mem_wen;
    assign d_req = d_mem_ren | d_mem_wen;

    // last_grant: 1 means the D-cache received the most recent grant.
    always_comb begin
        arb_pick = IDLE;
        if (i_req && d_req) begin
`ifdef ARB_ROUND_ROBIN_EN
            arb_pick = last_grant ? I_OWN : D_OWN;
`else
            arb_pick = D_OWN;
`endif
        end else if (d_req) begin
            arb_pick = D_OWN;
        end else if (i_req) begin
            arb_pick = I_OWN;
        end
    end

    always_comb begin
        own_ren   = 1'b0;
        own_wen   = 1'b0;
        own_addr  = '0;
        own_wdata = '0;
        case (state)
            I_OWN: begin
                own_ren   = i_mem_ren;
                own_wen   = i_mem_wen;
                own_addr  = i_mem_addr;
                own_wdata = i_mem_wdata;
            end
            D_OWN: begin
                own_ren   = d_mem_ren;
                own_wen   = d_mem_wen;
                own_addr  = d_mem_addr;
                own_wdata = d_mem_wdata;
            end
            default: ;
        endcase
    end

    // A write takes the slot in a cycle where the owner also asks for a read.
    assign own_req    = own_ren | own_wen;
    assign cnt_full   = (outst_cnt == CNT_MAX);
    assign cnt_zero   = (outst_cnt == '0);
    assign fwd_ren    = own_ren & ~own_wen & ~cnt_full;
    assign own_stall  = own_ren & (own_wen | cnt_full);
    assign take_valid = mem_data_valid & ~cnt_zero;

    assign mem_ren          = ~rst & fwd_ren;
    assign mem_wen          = ~rst & own_wen;
    assign mem_addr         = rst ? '0 : own_addr;
    assign mem_wdata        = rst ? '0 : own_wdata;
    assign i_mem_rdata      = mem_rdata;
    assign d_mem_rdata      = mem_rdata;
    assign i_mem_data_valid = ~rst & take_valid & (state == I_OWN);
    assign d_mem_data_valid = ~rst & take_valid & (state == D_OWN);
    assign i_stall          = rst | ((state == I_OWN) ? own_stall : i_req);
    assign d_stall          = rst | ((state == D_OWN) ? own_stall : d_req);

    always_comb begin
        state_next      = state;
        last_grant_next = last_grant;
        cnt_next        = outst_cnt;
        case ({fwd_ren, take_valid})
            2'b10:   cnt_next = outst_cnt + CNT_W'(1);
            2'b01:   cnt_next = outst_cnt - CNT_W'(1);
            default: cnt_next = outst_cnt;
        endcase
        case (state)
            IDLE: state_next = arb_pick;
            I_OWN, D_OWN: begin
                // Ownership is only given up once every read of the fill has returned.
                if (!own_req && cnt_zero && !mem_data_valid) begin
                    state_next = arb_pick;
                end
            end
            default: state_next = IDLE;
        endcase
        if (state_next != IDLE && state_next != state) begin
            last_grant_next = (state_next == D_OWN);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            outst_cnt  <= '0;
            last_grant <= 1'b1;
        end else begin
            state      <= state_next;
            outst_cnt  <= cnt_next;
            last_grant <= last_grant_next;
        end
    end

endmodule
